// File: rtl/pipe_adder_sat.sv
// Pipelined WIDTH-bit adder: STAGES carry-propagate segments with a registered
// carry between them, optional signed saturation, valid/ready on both sides.
module pipe_adder_sat #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SAT,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY,
  output logic             OVF
);
  localparam int SEG = WIDTH / STAGES;

  // The whole pipe moves in lockstep; bubbles are held rather than collapsed.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE = k * SEG;
    localparam int REM  = WIDTH - DONE;

    logic [REM-1:0]      aCur;
    logic [REM-1:0]      bCur;
    logic                cCur;
    logic                vCur;
    logic                satCur;
    logic [SEG:0]        segSum;
    logic [DONE+SEG-1:0] acc_d;

    if (k == 0) begin : g_src
      assign aCur   = A;
      assign bCur   = B;
      assign cCur   = CIN;
      assign vCur   = in_valid;
      assign satCur = SAT;
      assign acc_d  = segSum[SEG-1:0];
    end else begin : g_link
      assign aCur   = g_stage[k-1].g_mid.aRem_q;
      assign bCur   = g_stage[k-1].g_mid.bRem_q;
      assign cCur   = g_stage[k-1].g_mid.carry_q;
      assign vCur   = g_stage[k-1].g_mid.valid_q;
      assign satCur = g_stage[k-1].g_mid.sat_q;
      assign acc_d  = {segSum[SEG-1:0], g_stage[k-1].g_mid.acc_q};
    end

    assign segSum = {1'b0, aCur[SEG-1:0]} + {1'b0, bCur[SEG-1:0]} + {{SEG{1'b0}}, cCur};

    if (k < STAGES - 1) begin : g_mid
      logic [REM-SEG-1:0]  aRem_q;
      logic [REM-SEG-1:0]  bRem_q;
      logic [DONE+SEG-1:0] acc_q;
      logic                carry_q;
      logic                valid_q;
      logic                sat_q;

      // Upper operand segments ride along until their stage consumes them.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          aRem_q  <= '0;
          bRem_q  <= '0;
          acc_q   <= '0;
          carry_q <= 1'b0;
          valid_q <= 1'b0;
          sat_q   <= 1'b0;
        end else if (adv) begin
          aRem_q  <= aCur[REM-1:SEG];
          bRem_q  <= bCur[REM-1:SEG];
          acc_q   <= acc_d;
          carry_q <= segSum[SEG];
          valid_q <= vCur;
          sat_q   <= satCur;
        end
      end
    end else begin : g_last
      logic             ovf_d;
      logic [WIDTH-1:0] sum_d;

      // The top segment still holds the operand sign bits at this point.
      assign ovf_d = (aCur[SEG-1] == bCur[SEG-1]) && (acc_d[WIDTH-1] != aCur[SEG-1]);
      assign sum_d = (satCur && ovf_d)
                   ? (aCur[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                   : acc_d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          SUM       <= '0;
          CARRY     <= 1'b0;
          OVF       <= 1'b0;
        end else if (adv) begin
          out_valid <= vCur;
          if (vCur) begin
            SUM   <= sum_d;
            CARRY <= segSum[SEG];
            OVF   <= ovf_d;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_adder_sat.sv
// Directed bench for pipe_adder_sat: one 8-bit/2-stage instance and two
// 16-bit instances (1 and 4 stages) sharing stimulus, one selected at a time.
module tb_pipe_adder_sat;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        inValid;
  logic        cin;
  logic        sat;
  logic        outReady;
  logic [15:0] aIn;
  logic [15:0] bIn;
  int          sel = 0;
  int          checks = 0;
  int          fails = 0;

  logic iv0, iv1, iv2;
  assign iv0 = inValid && (sel == 0);
  assign iv1 = inValid && (sel == 1);
  assign iv2 = inValid && (sel == 2);

  logic        ir0, ov0, cy0, of0;
  logic [7:0]  sm0;
  logic        ir1, ov1, cy1, of1;
  logic [15:0] sm1;
  logic        ir2, ov2, cy2, of2;
  logic [15:0] sm2;

  pipe_adder_sat #(.WIDTH(8), .STAGES(2)) dutW8S2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
    .A(aIn[7:0]), .B(bIn[7:0]), .CIN(cin), .SAT(sat),
    .out_valid(ov0), .out_ready(outReady), .SUM(sm0), .CARRY(cy0), .OVF(of0)
  );

  pipe_adder_sat #(.WIDTH(16), .STAGES(1)) dutW16S1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .A(aIn), .B(bIn), .CIN(cin), .SAT(sat),
    .out_valid(ov1), .out_ready(outReady), .SUM(sm1), .CARRY(cy1), .OVF(of1)
  );

  pipe_adder_sat #(.WIDTH(16), .STAGES(4)) dutW16S4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .A(aIn), .B(bIn), .CIN(cin), .SAT(sat),
    .out_valid(ov2), .out_ready(outReady), .SUM(sm2), .CARRY(cy2), .OVF(of2)
  );

  logic        obsReady, obsValid, obsCarry, obsOvf;
  logic [15:0] obsSum;
  always_comb begin
    obsReady = ir0;
    obsValid = ov0;
    obsSum   = {8'h00, sm0};
    obsCarry = cy0;
    obsOvf   = of0;
    if (sel == 1) begin
      obsReady = ir1; obsValid = ov1; obsSum = sm1; obsCarry = cy1; obsOvf = of1;
    end else if (sel == 2) begin
      obsReady = ir2; obsValid = ov2; obsSum = sm2; obsCarry = cy2; obsOvf = of2;
    end
  end

  function automatic int widthOf(int s);
    return (s == 0) ? 8 : 16;
  endfunction

  function automatic int stagesOf(int s);
    return (s == 0) ? 2 : ((s == 1) ? 1 : 4);
  endfunction

  function automatic string dutName(int s);
    return (s == 0) ? "W8S2" : ((s == 1) ? "W16S1" : "W16S4");
  endfunction

  // Whole-word reference: {ovf, carry, sum} for a w-bit add.
  function automatic logic [17:0] model(int w, logic [15:0] a, logic [15:0] b, logic c, logic s);
    logic [16:0] t;
    logic [15:0] mask, raw, res;
    logic        cy, am, bm, ov;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    t    = {1'b0, a & mask} + {1'b0, b & mask} + {16'h0000, c};
    raw  = t[15:0] & mask;
    cy   = (w == 16) ? t[16] : t[8];
    am   = a[w-1];
    bm   = b[w-1];
    ov   = (am == bm) && (raw[w-1] != am);
    res  = (s && ov) ? (am ? (16'h8000 >> (16 - w)) : (mask >> 1)) : raw;
    return {ov, cy, res};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inValid = 1'b0; outReady = 1'b1;
    aIn = 16'h0; bIn = 16'h0; cin = 1'b0; sat = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if ({obsValid, obsReady, obsCarry, obsOvf, obsSum} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
        fails++;
        $display("[TB] FAIL reset %s: got valid/ready/carry/ovf/sum %b%b%b%b %h, expected 0100 0000",
                 dutName(s), obsValid, obsReady, obsCarry, obsOvf, obsSum);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    logic [15:0] va[7], vb[7], es[7];
    logic        vc[7], vs[7], ec[7], eo[7];
    int          st;
    st = stagesOf(sel);
    outReady = 1'b1;
    if (sel == 0) begin
      va = '{16'h00FF, 16'h007F, 16'h007F, 16'h0080, 16'h0080, 16'h000F, 16'h00C0};
      vb = '{16'h0001, 16'h0001, 16'h0001, 16'h00FF, 16'h00FF, 16'h0000, 16'h00C0};
      vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      es = '{16'h0000, 16'h0080, 16'h007F, 16'h0080, 16'h007F, 16'h0010, 16'h0080};
      ec = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      eo = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    end else begin
      va = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h00FF, 16'h1234, 16'hFFFE};
      vb = '{16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h4321, 16'hFFFF};
      vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      es = '{16'h0000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0100, 16'h5556, 16'hFFFD};
      ec = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      eo = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    end
    for (int i = 0; i < 7; i++) begin
      aIn = va[i]; bIn = vb[i]; cin = vc[i]; sat = vs[i]; inValid = 1'b1;
      #1;
      checks++;
      if (obsReady !== 1'b1) begin
        fails++;
        $display("[TB] FAIL arith_ready %s #%0d: got %b, expected 1", dutName(sel), i, obsReady);
      end
      tick();
      inValid = 1'b0; aIn = 16'hDEAD; bIn = 16'hBEEF; cin = ~vc[i]; sat = ~vs[i];
      for (int j = 1; j < st; j++) begin
        checks++;
        if (obsValid !== 1'b0) begin
          fails++;
          $display("[TB] FAIL arith_latency %s #%0d edge %0d: got valid %b, expected 0", dutName(sel), i, j, obsValid);
        end
        tick();
      end
      checks++;
      if ({obsValid, obsOvf, obsCarry, obsSum} !== {1'b1, eo[i], ec[i], es[i]}) begin
        fails++;
        $display("[TB] FAIL arith %s #%0d: got valid/ovf/carry/sum %b%b%b %h, expected 1%b%b %h",
                 dutName(sel), i, obsValid, obsOvf, obsCarry, obsSum, eo[i], ec[i], es[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va[20], vb[20];
    logic        vc[20], vs[20];
    logic [17:0] ex[20];
    int          st, w;
    st = stagesOf(sel);
    w  = widthOf(sel);
    for (int i = 0; i < 20; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
      vc[i] = 1'($urandom);
      vs[i] = (i % 3 == 0);
    end
    va[3] = 16'h7F7F; vb[3] = 16'h0101; vc[3] = 1'b0;
    va[7] = 16'h8080; vb[7] = 16'h8080; vs[7] = 1'b1;
    for (int i = 0; i < 20; i++) ex[i] = model(w, va[i], vb[i], vc[i], vs[i]);
    outReady = 1'b1;
    for (int s = 0; s <= 20 + st; s++) begin
      logic expV;
      expV = (s >= st) && (s - st < 20);
      checks++;
      if (obsValid !== expV) begin
        fails++;
        $display("[TB] FAIL b2b_valid %s step %0d: got %b, expected %b", dutName(sel), s, obsValid, expV);
      end
      if (expV) begin
        checks++;
        if ({obsOvf, obsCarry, obsSum} !== ex[s-st]) begin
          fails++;
          $display("[TB] FAIL b2b_result %s #%0d: got %h, expected %h", dutName(sel), s - st,
                   {obsOvf, obsCarry, obsSum}, ex[s-st]);
        end
      end
      if (s < 20) begin
        aIn = va[s]; bIn = vb[s]; cin = vc[s]; sat = vs[s]; inValid = 1'b1;
      end else begin
        inValid = 1'b0;
      end
      tick();
    end
    inValid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [17:0] q[$];
    logic [15:0] va[12], vb[12];
    logic        vc[12], vs[12];
    logic [15:0] prevSum;
    logic        prevStall;
    int          idx, popped, w;
    w = widthOf(sel);
    idx = 0; popped = 0; prevStall = 1'b0; prevSum = 16'h0;
    for (int i = 0; i < 12; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
      vc[i] = 1'($urandom);
      vs[i] = 1'($urandom);
    end
    for (int s = 0; s < 80; s++) begin
      logic        stall;
      logic [17:0] exp;
      outReady = (s >= 4 && s < 7) ? 1'b0 : ((s >= 10 && s < 24) ? (s % 2 == 0) : 1'b1);
      if (idx < 12) begin
        aIn = va[idx]; bIn = vb[idx]; cin = vc[idx]; sat = vs[idx]; inValid = 1'b1;
      end else begin
        inValid = 1'b0;
      end
      #1;
      stall = obsValid && !outReady;
      if (stall) begin
        checks++;
        if (obsReady !== 1'b0) begin
          fails++;
          $display("[TB] FAIL stall_ready %s step %0d: got %b, expected 0", dutName(sel), s, obsReady);
        end
        if (prevStall) begin
          checks++;
          if (obsSum !== prevSum) begin
            fails++;
            $display("[TB] FAIL stall_hold %s step %0d: got %h, expected %h", dutName(sel), s, obsSum, prevSum);
          end
        end
      end
      if (obsValid && outReady) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("[TB] FAIL bp_extra %s step %0d: got unexpected result %h, expected none", dutName(sel), s, obsSum);
        end else begin
          exp = q.pop_front();
          popped++;
          if ({obsOvf, obsCarry, obsSum} !== exp) begin
            fails++;
            $display("[TB] FAIL bp_result %s #%0d: got %h, expected %h", dutName(sel), popped - 1,
                     {obsOvf, obsCarry, obsSum}, exp);
          end
        end
      end
      if (inValid && obsReady) begin
        q.push_back(model(w, va[idx], vb[idx], vc[idx], vs[idx]));
        idx++;
      end
      prevStall = stall;
      prevSum   = obsSum;
      tick();
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    checks++;
    if (popped !== 12) begin
      fails++;
      $display("[TB] FAIL bp_count %s: got %0d results, expected 12", dutName(sel), popped);
    end
  endtask

  task automatic test_reset_mid();
    int          st;
    logic [15:0] expSum;
    st = stagesOf(sel);
    expSum = (sel == 0) ? 16'h0010 : 16'h1010;
    outReady = 1'b1;
    for (int i = 0; i < st + 1; i++) begin
      aIn = 16'h1111 + 16'(i); bIn = 16'h2222; cin = 1'b0; sat = 1'b0; inValid = 1'b1;
      tick();
    end
    checks++;
    if (obsValid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rstmid_pre %s: got valid %b, expected 1", dutName(sel), obsValid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({obsValid, obsReady, obsCarry, obsOvf, obsSum} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
      fails++;
      $display("[TB] FAIL rstmid %s: got valid/ready/carry/ovf/sum %b%b%b%b %h, expected 0100 0000",
               dutName(sel), obsValid, obsReady, obsCarry, obsOvf, obsSum);
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
    rst_n   = 1'b1;
    for (int j = 0; j < st + 2; j++) begin
      tick();
      checks++;
      if (obsValid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL rstmid_stale %s cycle %0d: got valid %b, expected 0", dutName(sel), j, obsValid);
      end
    end
    aIn = 16'h0F0F; bIn = 16'h0101; cin = 1'b0; sat = 1'b0; inValid = 1'b1;
    tick();
    inValid = 1'b0;
    for (int j = 1; j < st; j++) tick();
    checks++;
    if ({obsValid, obsOvf, obsCarry, obsSum} !== {1'b1, 1'b0, 1'b0, expSum}) begin
      fails++;
      $display("[TB] FAIL rstmid_after %s: got valid/ovf/carry/sum %b%b%b %h, expected 100 %h",
               dutName(sel), obsValid, obsOvf, obsCarry, obsSum, expSum);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      $display("[TB] testing %s", dutName(s));
      test_arith();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipe_adder_sat.md
Name: pipe_adder_sat

Overview:
- Parametrised, pipelined successor to the team's 1-bit half adder.
- Computes A + B + CIN over WIDTH bits, split into STAGES carry-propagate segments with a registered carry between segments.
- Per-transaction signed-saturation mode; valid/ready handshake with backpressure.
- Used as the add/accumulate-stage building block in the CNN accelerator datapath (partial-sum and bias addition).

Parameters:
- WIDTH, 16, operand/result width in bits; must be divisible by STAGES.
- STAGES, 2, number of pipeline segments, 1..WIDTH. Segment width SEG = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block accepts operands this cycle
- A  input  WIDTH  operand A (two's complement when SAT=1)
- B  input  WIDTH  operand B
- CIN  input  1  carry-in
- SAT  input  1  1 = clamp on signed overflow, 0 = wrap
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- SUM  output  WIDTH  result (raw or saturated)
- CARRY  output  1  unsigned carry-out of the raw WIDTH-bit sum
- OVF  output  1  signed overflow of the raw sum

Behaviour:
- Reset (rst_n low, async): all stage valid bits, out_valid, SUM, CARRY and OVF clear to 0 immediately. In-flight data is discarded. in_ready reflects the cleared pipeline, so it is 1.
- Pipeline advance: adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - All stage registers load only when adv = 1; otherwise every stage holds, including bubbles. Bubbles are not collapsed.
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Latency: exactly STAGES clock edges from input transfer to out_valid, given no stall. Throughput is 1 per cycle while out_ready = 1.
- Stage k (k = 0..STAGES-1):
  - Adds A[k*SEG +: SEG] + B[k*SEG +: SEG] + c_k, where c_0 = CIN and c_k is the registered carry from stage k-1.
  - Result bits are registered and travel with the transaction.
  - Unprocessed upper operand segments, SAT and the valid bit are delayed alongside.
- Final stage:
  - raw = concatenated segment sums.
  - CARRY = carry out of the top segment.
  - OVF = (A[MSB] == B[MSB]) && (raw[MSB] != A[MSB]). A and B MSBs are carried through the pipeline for this.
  - CIN participates in the sum; OVF is based on the raw result.
- Saturation:
  - SAT=1 and OVF=1: SUM = 0x7F..F if A[MSB]=0, else 0x80..0.
  - Otherwise SUM = raw.
  - CARRY and OVF always report raw-sum status.
- Holding: SUM, CARRY and OVF hold stable while out_valid=1 && out_ready=0. When out_valid=0 they hold their last values (no X, not required to clear).
- STAGES=1: a single registered adder with latency 1.
- Stall boundary: out_ready may toggle every cycle; no transaction is lost, duplicated or reordered.
- Inputs are sampled only on an input transfer. A/B/CIN/SAT may change freely otherwise.
- Reset mid-operation: all pending results are dropped. The first transfer after rst_n deasserts behaves as from power-up.

Test Plan:
- WIDTH=8, STAGES=2: A=FF, B=01, CIN=0, SAT=0 -> after 2 cycles out_valid=1, SUM=00, CARRY=1, OVF=0.
- A=7F, B=01, SAT=0 -> SUM=80, OVF=1, CARRY=0. Same operands with SAT=1 -> SUM=7F, OVF=1.
- A=80, B=FF, CIN=0, SAT=1 -> SUM=80 (clamped), CARRY=1, OVF=1. With SAT=0 -> SUM=7F.
- Carry across segment boundary: A=0F, B=00, CIN=1 -> SUM=10, CARRY=0, with the stage-0 carry propagated into stage 1.
- Streaming: 20 back-to-back random transfers with out_ready=1 -> one result per cycle in order, each matching the reference model, latency 2.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles with the pipeline full -> in_ready=0, SUM stable, no loss after release.
  - Assert rst_n=0 mid-stream -> out_valid=0 the same cycle, SUM/CARRY/OVF=0, in_ready=1.
  - Repeat with STAGES=1 and STAGES=4 (WIDTH=16).
